correlator_scheduler: RTL and testbench

//  Single-clock sequencer for the Gold-code correlator datapath. Divides clk into sample slots,

---
 rtl/correlator_scheduler_pkg.sv | 21 ++
 rtl/correlator_scheduler_if.sv | 32 +++
 rtl/correlator_scheduler_sample_divider.sv | 48 ++++
 rtl/correlator_scheduler.sv | 126 ++++++++++++
 tb/tb_correlator_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/correlator_scheduler_pkg.sv
// Shared constants and FSM state type for the correlator scheduler.
package correlator_scheduler_pkg;

    localparam int unsigned CodeLenDef   = 15;
    localparam int unsigned NumPhasesDef = 4;
    localparam int unsigned AccW         = 8;
    // Smallest slot that fits a full two-code sweep plus the idle cycle before the next tick.
    localparam int unsigned SampleDivMin = 2 * CodeLenDef + 6;

    typedef enum logic [2:0] {
        StIdle,
        StClrRef,
        StSweepRef,
        StWaitRef,
        StLatchRef,
        StSweepOrth,
        StWaitOrth,
        StLatchOrth
    } state_e;

endpackage

// File: rtl/correlator_scheduler_if.sv
// Control/result bundle between the scheduler and the correlator datapath.
interface correlator_scheduler_if;
    import correlator_scheduler_pkg::*;

    logic                   enable;
    logic                   ovr_clr;
    logic signed [AccW-1:0] acc_in;
    logic                   sample_en;
    logic [1:0]             phase;
    logic                   acc_clr;
    logic                   acc_en;
    logic [7:0]             tap_idx;
    logic                   code_sel;
    logic signed [AccW-1:0] ref_corr;
    logic signed [AccW-1:0] orth_corr;
    logic                   corr_valid;
    logic                   busy;
    logic                   overrun;

    modport master (
        input  enable, ovr_clr, acc_in,
        output sample_en, phase, acc_clr, acc_en, tap_idx, code_sel,
               ref_corr, orth_corr, corr_valid, busy, overrun
    );

    modport slave (
        output enable, ovr_clr, acc_in,
        input  sample_en, phase, acc_clr, acc_en, tap_idx, code_sel,
               ref_corr, orth_corr, corr_valid, busy, overrun
    );

endinterface

// File: rtl/correlator_scheduler_sample_divider.sv
// Sample-slot divider: produces one tick per SAMPLE_DIV cycles and the round-robin phase.
module correlator_scheduler_sample_divider #(
    parameter int unsigned SAMPLE_DIV = 64,
    parameter int unsigned NUM_PHASES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int unsigned CntW = $clog2(SAMPLE_DIV);
    localparam logic [CntW-1:0] DivMax  = CntW'(SAMPLE_DIV - 1);
    localparam logic [1:0]      PhaseMax = 2'(NUM_PHASES - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      phase_q, phase_d;

    // Next-state: divider parks at 0 while disabled; phase steps once per tick.
    always_comb begin
        tick      = enable && (div_cnt_q == DivMax);
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        if (!enable || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
        if (tick) begin
            phase_d = (phase_q == PhaseMax) ? 2'd0 : phase_q + 2'd1;
        end
    end

    // Divider and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/correlator_scheduler.sv
// Sweep sequencer for the Gold-code correlator: reference sweep, then orthogonal sweep,
// then both sums latched and flagged once per sample slot.
module correlator_scheduler
    import correlator_scheduler_pkg::*;
#(
    parameter int unsigned CODE_LEN   = CodeLenDef,
    parameter int unsigned NUM_PHASES = NumPhasesDef,
    parameter int unsigned SAMPLE_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    correlator_scheduler_if.master bus
);

    localparam logic [7:0] TapLast = 8'(CODE_LEN - 1);

    logic                   tick;
    state_e                 state_q, state_d;
    logic [7:0]             tap_q, tap_d;
    logic signed [AccW-1:0] ref_q, ref_d;
    logic signed [AccW-1:0] orth_q, orth_d;
    logic                   ovr_q, ovr_d;

    correlator_scheduler_sample_divider #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .NUM_PHASES (NUM_PHASES)
    ) u_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (bus.enable),
        .tick   (tick),
        .phase  (bus.phase)
    );

    // FSM next-state, datapath strobes and result latching.
    always_comb begin
        state_d         = state_q;
        tap_d           = '0;
        ref_d           = ref_q;
        orth_d          = orth_q;
        ovr_d           = ovr_q;
        bus.acc_clr     = 1'b0;
        bus.acc_en      = 1'b0;
        bus.tap_idx     = '0;
        bus.code_sel    = 1'b0;
        bus.corr_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick) state_d = StClrRef;
            end
            StClrRef: begin
                bus.acc_clr = 1'b1;
                state_d     = StSweepRef;
            end
            StSweepRef: begin
                bus.acc_en  = 1'b1;
                bus.tap_idx = tap_q;
                tap_d       = tap_q + 8'd1;
                if (tap_q == TapLast) begin
                    tap_d   = '0;
                    state_d = StWaitRef;
                end
            end
            StWaitRef: begin
                state_d = StLatchRef;
            end
            StLatchRef: begin
                bus.acc_clr  = 1'b1;
                bus.code_sel = 1'b1;
                if (!tick) ref_d = bus.acc_in;
                state_d      = StSweepOrth;
            end
            StSweepOrth: begin
                bus.acc_en   = 1'b1;
                bus.code_sel = 1'b1;
                bus.tap_idx  = tap_q;
                tap_d        = tap_q + 8'd1;
                if (tap_q == TapLast) begin
                    tap_d   = '0;
                    state_d = StWaitOrth;
                end
            end
            StWaitOrth: begin
                // Load here so orth_corr is already current while corr_valid is high.
                if (!tick) orth_d = bus.acc_in;
                state_d = StLatchOrth;
            end
            StLatchOrth: begin
                bus.corr_valid = !tick;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A tick while busy abandons the current sweep and restarts it.
        if (tick && (state_q != StIdle)) begin
            state_d = StClrRef;
            tap_d   = '0;
        end
        if (bus.ovr_clr) ovr_d = 1'b0;
        if (tick && (state_q != StIdle)) ovr_d = 1'b1;
    end

    // State, tap counter, result latches and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tap_q   <= '0;
            ref_q   <= '0;
            orth_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            ref_q   <= ref_d;
            orth_q  <= orth_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.sample_en = tick;
    assign bus.busy      = (state_q != StIdle);
    assign bus.ref_corr  = ref_q;
    assign bus.orth_corr = orth_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_correlator_scheduler.sv
// Bench for correlator_scheduler: three instances at slot lengths 64, 36 and 30, each fed by a
// behavioural accumulator that applies a random +/-1 code table.
module tb_correlator_scheduler;
    import correlator_scheduler_pkg::*;

    localparam int Lat = 2 * CodeLenDef + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    correlator_scheduler_if b64 ();
    correlator_scheduler_if b36 ();
    correlator_scheduler_if b30 ();

    correlator_scheduler #(.SAMPLE_DIV(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
    correlator_scheduler #(.SAMPLE_DIV(36)) u36 (.clk(clk), .rst_n(rst_n), .bus(b36));
    correlator_scheduler #(.SAMPLE_DIV(30)) u30 (.clk(clk), .rst_n(rst_n), .bus(b30));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ref_w [CodeLenDef];
    int orth_w [CodeLenDef];

    logic signed [AccW-1:0] acc64, acc36, acc30;
    logic [32:0] o64;

    // Datapath stand-in: clear, or add the selected code's weight at the given tap.
    function automatic logic signed [AccW-1:0] dp_next(input logic signed [AccW-1:0] acc,
                                                       input logic clr, input logic en,
                                                       input logic sel, input logic [7:0] tap);
        int w;
        if (clr) return '0;
        if (!en || tap >= 8'(CodeLenDef)) return acc;
        w = sel ? orth_w[tap] : ref_w[tap];
        return acc + AccW'(w);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc64 <= '0;
        else acc64 <= dp_next(acc64, b64.acc_clr, b64.acc_en, b64.code_sel, b64.tap_idx);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc36 <= '0;
        else acc36 <= dp_next(acc36, b36.acc_clr, b36.acc_en, b36.code_sel, b36.tap_idx);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc30 <= '0;
        else acc30 <= dp_next(acc30, b30.acc_clr, b30.acc_en, b30.code_sel, b30.tap_idx);
    end
    assign b64.acc_in = acc64;
    assign b36.acc_in = acc36;
    assign b30.acc_in = acc30;

    assign o64 = {b64.sample_en, b64.phase, b64.acc_clr, b64.acc_en, b64.tap_idx, b64.code_sel,
                  b64.ref_corr, b64.orth_corr, b64.corr_valid, b64.busy, b64.overrun};

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic e64, input logic e36, input logic e30);
        rst_n = 1'b0;
        b64.enable = e64; b36.enable = e36; b30.enable = e30;
        b64.ovr_clr = 1'b0; b36.ovr_clr = 1'b0; b30.ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic set_codes(input bit ones);
        for (int i = 0; i < CodeLenDef; i++) begin
            ref_w[i]  = ones ? 1 : ($urandom_range(0, 1) ? 1 : -1);
            orth_w[i] = ones ? 1 : ($urandom_range(0, 1) ? 1 : -1);
        end
    endtask

    function automatic int sum_ref();
        int s = 0;
        for (int i = 0; i < CodeLenDef; i++) s += ref_w[i];
        return s;
    endfunction

    function automatic int sum_orth();
        int s = 0;
        for (int i = 0; i < CodeLenDef; i++) s += orth_w[i];
        return s;
    endfunction

    task automatic wait_se64(input int limit, input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (b64.sample_en !== 1'b1 && n < limit);
        checks++;
        if (b64.sample_en !== 1'b1) begin
            errors++;
            $display("FAIL %s: no sample_en within %0d cycles", name, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b64.enable = 1'($urandom_range(0, 1));
        b36.enable = 1'($urandom_range(0, 1));
        b30.enable = 1'b1;
        b64.ovr_clr = 1'b0; b36.ovr_clr = 1'b0; b30.ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o64 !== '0) begin errors++; $display("FAIL reset_u64: got %h want 0", o64); end
        checks++;
        if ({b36.sample_en, b36.phase, b36.busy, b36.ref_corr, b36.corr_valid} !== '0) begin
            errors++; $display("FAIL reset_u36: outputs not zero");
        end
        checks++;
        if ({b30.sample_en, b30.phase, b30.busy, b30.overrun, b30.acc_clr} !== '0) begin
            errors++; $display("FAIL reset_u30: outputs not zero");
        end
    endtask

    task automatic test_divider();
        int ticks = 0;
        do_reset(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 330; c++) begin
            step();
            checks++;
            if (b64.sample_en !== ((cyc % 64) == 63)) begin
                errors++;
                $display("FAIL div_tick: cyc %0d sample_en=%b want %b", cyc, b64.sample_en,
                         (cyc % 64) == 63);
            end
            if ((cyc % 64) == 63) begin
                checks++;
                if (b64.phase !== 2'(ticks % 4)) begin
                    errors++;
                    $display("FAIL div_phase: tick %0d phase=%0d want %0d", ticks, b64.phase,
                             ticks % 4);
                end
                ticks++;
            end
        end
    endtask

    task automatic test_sweep();
        int n, en_cnt, cv_cnt, cv_at, sr, so;
        do_reset(1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            set_codes(r == 0);
            sr = sum_ref();
            so = sum_orth();
            wait_se64(100, "sweep_tick", n);
            en_cnt = 0; cv_cnt = 0; cv_at = -1;
            for (int k = 1; k <= 40; k++) begin
                step();
                checks++;
                if (b64.busy !== (k <= Lat)) begin
                    errors++; $display("FAIL sweep_busy: k=%0d busy=%b", k, b64.busy);
                end
                checks++;
                if ((b64.acc_clr & b64.acc_en) !== 1'b0) begin
                    errors++; $display("FAIL sweep_clr_en: k=%0d both high", k);
                end
                if (b64.acc_en) begin
                    checks++;
                    if (b64.tap_idx !== 8'(en_cnt % CodeLenDef) ||
                        b64.code_sel !== (en_cnt >= CodeLenDef)) begin
                        errors++;
                        $display("FAIL sweep_tap: step %0d tap=%0d sel=%b want %0d %b", en_cnt,
                                 b64.tap_idx, b64.code_sel, en_cnt % CodeLenDef,
                                 en_cnt >= CodeLenDef);
                    end
                    en_cnt++;
                end else if (!b64.acc_clr) begin
                    checks++;
                    if (b64.tap_idx !== 8'd0 || b64.code_sel !== 1'b0) begin
                        errors++;
                        $display("FAIL sweep_idle_tap: k=%0d tap=%0d sel=%b", k, b64.tap_idx,
                                 b64.code_sel);
                    end
                end
                if (b64.corr_valid) begin
                    cv_cnt++;
                    cv_at = k;
                    checks++;
                    if (b64.ref_corr !== AccW'(sr)) begin
                        errors++;
                        $display("FAIL sweep_ref: got %0d want %0d", b64.ref_corr, sr);
                    end
                    checks++;
                    if (b64.orth_corr !== AccW'(so)) begin
                        errors++;
                        $display("FAIL sweep_orth: got %0d want %0d", b64.orth_corr, so);
                    end
                end
            end
            checks++;
            if (en_cnt != 2 * CodeLenDef) begin
                errors++; $display("FAIL sweep_en_count: got %0d want %0d", en_cnt, 2 * CodeLenDef);
            end
            checks++;
            if (cv_cnt != 1 || cv_at != Lat) begin
                errors++;
                $display("FAIL sweep_latency: count %0d at %0d want 1 at %0d", cv_cnt, cv_at, Lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sr, so;
        bit exp_cv;
        set_codes(1'b0);
        sr = sum_ref();
        so = sum_orth();
        do_reset(1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 260; c++) begin
            step();
            exp_cv = (cyc >= 35 + Lat) && (((cyc - 35 - Lat) % 36) == 0);
            checks++;
            if (b36.sample_en !== ((cyc % 36) == 35)) begin
                errors++; $display("FAIL b2b_tick: cyc %0d sample_en=%b", cyc, b36.sample_en);
            end
            checks++;
            if (b36.corr_valid !== exp_cv) begin
                errors++;
                $display("FAIL b2b_valid: cyc %0d got %b want %b", cyc, b36.corr_valid, exp_cv);
            end
            checks++;
            if (b36.overrun !== 1'b0) begin
                errors++; $display("FAIL b2b_overrun: cyc %0d got 1 want 0", cyc);
            end
            if (exp_cv) begin
                checks++;
                if (b36.ref_corr !== AccW'(sr) || b36.orth_corr !== AccW'(so)) begin
                    errors++;
                    $display("FAIL b2b_values: got %0d/%0d want %0d/%0d", b36.ref_corr,
                             b36.orth_corr, sr, so);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int sweep_end = -1;
        bit ovr_exp = 1'b0;
        bit tick_c, exp_cv;
        do_reset(1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 200; c++) begin
            step();
            tick_c = (cyc % 30) == 29;
            exp_cv = (cyc == sweep_end) && !tick_c;
            checks++;
            if (b30.sample_en !== tick_c) begin
                errors++; $display("FAIL ovr_tick: cyc %0d sample_en=%b", cyc, b30.sample_en);
            end
            checks++;
            if (b30.corr_valid !== exp_cv) begin
                errors++;
                $display("FAIL ovr_valid: cyc %0d got %b want %b", cyc, b30.corr_valid, exp_cv);
            end
            checks++;
            if (b30.overrun !== ovr_exp) begin
                errors++;
                $display("FAIL ovr_flag: cyc %0d got %b want %b", cyc, b30.overrun, ovr_exp);
            end
            if (cyc == 60) begin
                checks++;
                if (b30.busy !== 1'b1 || b30.acc_clr !== 1'b1 || b30.acc_en !== 1'b0 ||
                    b30.code_sel !== 1'b0) begin
                    errors++; $display("FAIL ovr_restart: not in reference clear after overrun");
                end
            end
            b30.ovr_clr = (cyc == 100) || (cyc == 130) || (cyc == 149);
            if (b30.ovr_clr) ovr_exp = 1'b0;
            if (tick_c) begin
                if (cyc <= sweep_end) ovr_exp = 1'b1;
                sweep_end = cyc + Lat;
            end
        end
        b30.ovr_clr = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n, sr, so;
        set_codes(1'b0);
        sr = sum_ref();
        so = sum_orth();
        do_reset(1'b1, 1'b0, 1'b0);
        wait_se64(100, "drop_tick", n);
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++;
            if (b64.corr_valid !== (k == Lat)) begin
                errors++; $display("FAIL drop_valid: k=%0d got %b", k, b64.corr_valid);
            end
            if (k == Lat) begin
                checks++;
                if (b64.ref_corr !== AccW'(sr) || b64.orth_corr !== AccW'(so)) begin
                    errors++;
                    $display("FAIL drop_values: got %0d/%0d want %0d/%0d", b64.ref_corr,
                             b64.orth_corr, sr, so);
                end
            end
            if (k == 10) b64.enable = 1'b0;
        end
        for (int k = 0; k < 150; k++) begin
            step();
            checks++;
            if (b64.sample_en !== 1'b0 || b64.busy !== 1'b0) begin
                errors++; $display("FAIL drop_quiet: cyc %0d sample_en/busy active", cyc);
            end
        end
        b64.enable = 1'b1;
        wait_se64(100, "reenable_tick", n);
        checks++;
        if (n != 63) begin
            errors++; $display("FAIL reenable_delay: got %0d want 63", n);
        end
        checks++;
        if (b64.phase !== 2'd1) begin
            errors++; $display("FAIL reenable_phase: got %0d want 1", b64.phase);
        end
    endtask

    task automatic test_reset_mid();
        int n, sr;
        sr = sum_ref();
        wait_se64(100, "mid_tick", n);
        repeat (20) step();
        checks++;
        if (b64.acc_en !== 1'b1 || b64.busy !== 1'b1 || b64.ref_corr !== AccW'(sr)) begin
            errors++;
            $display("FAIL mid_presweep: acc_en=%b busy=%b ref=%0d want 1 1 %0d", b64.acc_en,
                     b64.busy, b64.ref_corr, sr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o64 !== '0) begin errors++; $display("FAIL mid_async_reset: got %h want 0", o64); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        wait_se64(100, "post_reset_tick", n);
        checks++;
        if (n != 63) begin errors++; $display("FAIL post_reset_delay: got %0d want 63", n); end
        checks++;
        if (b64.phase !== 2'd0) begin
            errors++; $display("FAIL post_reset_phase: got %0d want 0", b64.phase);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_sweep();
        test_back_to_back();
        test_overrun();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
